// File: rtl/sram_controller.sv
// Splits 32-bit MEM-stage loads/stores into two half-word phases on a 16-bit async SRAM.
// Optional one-word read buffer enabled by defining SRAM_CTRL_READ_BUF_EN.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter logic [31:0] ADDR_BASE   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ce_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [16:0] idx_reg;
  logic [31:0] wdata_reg;
  logic        is_write_reg;
  logic [15:0] lo_reg;

  logic [31:0] offset;
  logic [16:0] req_idx;
  logic        req;
  logic        buf_hit;
  logic        unused_offset_bits;

  // Word index keeps only 17 bits, so out-of-range addresses alias silently.
  assign offset             = address - ADDR_BASE;
  assign req_idx            = offset[18:2];
  assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
  assign req                = mem_read | mem_write;

`ifdef SRAM_CTRL_READ_BUF_EN
  logic        buf_valid_reg;
  logic [16:0] buf_tag_reg;
  logic [31:0] buf_data_reg;

  assign buf_hit = (state_reg == IDLE) && mem_read && !mem_write &&
                   buf_valid_reg && (buf_tag_reg == req_idx);

  // Stores to the tagged word refresh the copy when accepted, so a later hit
  // returns the data the SRAM will hold once the write completes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_valid_reg <= 1'b0;
      buf_tag_reg   <= '0;
      buf_data_reg  <= '0;
    end else begin
      if (state_reg == IDLE && mem_write && buf_valid_reg && buf_tag_reg == req_idx) begin
        buf_data_reg <= write_data;
      end else if (state_reg == HIGH && cnt_reg == LAST_CNT && !is_write_reg) begin
        buf_valid_reg <= 1'b1;
        buf_tag_reg   <= idx_reg;
        buf_data_reg  <= {sram_dq_in, lo_reg};
      end
    end
  end
`else
  assign buf_hit = 1'b0;
`endif

  always_comb begin
    ready = 1'b0;
    case (state_reg)
      IDLE:    ready = !req || buf_hit;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      wdata_reg    <= '0;
      is_write_reg <= 1'b0;
      lo_reg       <= '0;
      read_data    <= '0;
      sram_addr    <= '0;
      sram_dq_out  <= '0;
      sram_dq_oe   <= 1'b0;
      sram_we_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_ce_n    <= 1'b1;
      sram_ub_n    <= 1'b1;
      sram_lb_n    <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (buf_hit) begin
`ifdef SRAM_CTRL_READ_BUF_EN
            read_data <= buf_data_reg;
`endif
          end else if (req) begin
            // Capture everything now; request lines may change while frozen.
            idx_reg      <= req_idx;
            wdata_reg    <= write_data;
            is_write_reg <= mem_write;
            cnt_reg      <= '0;
            state_reg    <= LOW;
            sram_addr    <= {req_idx, 1'b0};
            sram_dq_out  <= write_data[15:0];
            sram_dq_oe   <= mem_write;
            sram_we_n    <= !mem_write;
            sram_oe_n    <= mem_write;
            sram_ce_n    <= 1'b0;
            sram_ub_n    <= 1'b0;
            sram_lb_n    <= 1'b0;
          end
        end
        LOW: begin
          if (cnt_reg == LAST_CNT) begin
            // Only the address LSB and data change at the phase boundary.
            lo_reg      <= sram_dq_in;
            cnt_reg     <= '0;
            state_reg   <= HIGH;
            sram_addr   <= {idx_reg, 1'b1};
            sram_dq_out <= wdata_reg[31:16];
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        HIGH: begin
          if (cnt_reg == LAST_CNT) begin
            cnt_reg    <= '0;
            state_reg  <= DONE;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_ce_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
            if (!is_write_reg) begin
              read_data <= {sram_dq_in, lo_reg};
            end
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
